prog_loader: RTL and testbench

Instruction encoder and program loader for the 16-bit core. It accepts symbolic instruction fields over a valid/ready handshake, packs them into 16-bit instruction words, and writes them sequentially into instruction memory. It is the writer-side counterpart of the control decoder. It also expands the `li` pseudo-instruction into a `lui`/`lli` pair. It sits between the host/debug port and the instruction memory write port and runs only while the core is held in reset.

---
 rtl/isa_pkg.sv | 51 +++++
 rtl/inst_encode.sv | 44 ++++
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core: opcodes, field positions,
// instruction formats and immediate ranges. The control decoder imports this as well.
package isa_pkg;

  localparam int WORD_W = 16;
  localparam int OP_W   = 4;
  localparam int REG_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_GRT  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_EQ   = 4'b0011;
  localparam logic [OP_W-1:0] OP_JALR = 4'b0100;
  localparam logic [OP_W-1:0] OP_LUI  = 4'b0101;
  localparam logic [OP_W-1:0] OP_JAL  = 4'b0110;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b1000;
  localparam logic [OP_W-1:0] OP_LW   = 4'b1001;
  localparam logic [OP_W-1:0] OP_SW   = 4'b1010;
  localparam logic [OP_W-1:0] OP_LLI  = 4'b1111;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  localparam int IMM_I_MIN  = -8;
  localparam int IMM_I_MAX  = 7;
  localparam int IMM_UL_MIN = 0;
  localparam int IMM_UL_MAX = 255;
  localparam int IMM_US_MIN = -128;
  localparam int IMM_US_MAX = 127;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_U} fmt_t;

  typedef enum logic {ST_IDLE, ST_LLI} load_state_t;

  // Any code not listed explicitly decodes as bne, which is U-type.
  function automatic fmt_t op_format(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_GRT, OP_SUB, OP_EQ:    return FMT_R;
      OP_JALR, OP_ADDI, OP_LW, OP_SW:   return FMT_I;
      OP_LUI, OP_LLI, OP_JAL:           return FMT_U;
      default:                          return FMT_U;
    endcase
  endfunction

  function automatic logic imm_is_unsigned(input logic [OP_W-1:0] op);
    return (op == OP_LUI) || (op == OP_LLI);
  endfunction

endpackage

// File: rtl/inst_encode.sv
// Combinational packer: symbolic fields to one 16-bit instruction word,
// with a check that the immediate fits the format of the opcode.
module inst_encode
  import isa_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [15:0]       imm,
  output logic [WORD_W-1:0] word,
  output logic              range_ok
);

  int simm;

  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    simm     = int'($signed(imm));
    word[OP_LSB +: OP_W] = op;
    word[RD_LSB +: REG_W] = rd;
    case (op_format(op))
      FMT_R: begin
        word[RS1_LSB +: REG_W] = rs1;
        word[RS2_LSB +: REG_W] = rs2;
        range_ok = 1'b1;
      end
      FMT_I: begin
        word[RS1_LSB +: REG_W] = rs1;
        word[RS2_LSB +: REG_W] = imm[REG_W-1:0];
        range_ok = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
      end
      default: begin
        word[7:0] = imm[7:0];
        if (imm_is_unsigned(op))
          range_ok = (simm >= IMM_UL_MIN) && (simm <= IMM_UL_MAX);
        else
          range_ok = (simm >= IMM_US_MIN) && (simm <= IMM_US_MAX);
      end
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts field bundles, encodes them and writes words
// sequentially into instruction memory; li becomes a lui/lli pair.
module prog_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_li,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output load_state_t       state
);

  // Handshake: a bundle transfers on a rising edge with in_valid && in_ready;
  // in_ready depends only on state, full and start, never on in_valid.

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  load_state_t       state_next;
  logic [3:0]        enc_op;
  logic [15:0]       enc_imm;
  logic [15:0]       enc_word;
  logic              range_ok;
  logic              accept;
  logic              reject;
  logic              wr_en;
  logic [15:0]       wr_data;
  logic              err_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       lli_word;

  // For li the encoder produces the lui half; the lli half is latched separately.
  assign enc_op  = in_li ? OP_LUI : in_op;
  assign enc_imm = in_li ? {8'h00, in_imm[15:8]} : in_imm;

  inst_encode u_encode (
    .op       (enc_op),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (enc_imm),
    .word     (enc_word),
    .range_ok (range_ok)
  );

  assign in_ready = !start && (state == ST_IDLE) && !full;
  assign accept   = in_valid && in_ready;
  assign reject   = !range_ok || (in_li && (count == DEPTH_C - 1'b1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_data    = enc_word;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (reject) begin
            err_next = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (in_li) state_next = ST_LLI;
          end
        end
      end
      ST_LLI: begin
        wr_en      = 1'b1;
        wr_data    = lli_word;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // start drops a pending lli word and rewinds in the same cycle.
    if (start) begin
      wr_en      = 1'b0;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_C;
      mem_wdata <= '0;
      wr_ptr    <= BASE_C;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      lli_word  <= '0;
    end else begin
      mem_we <= wr_en;
      err    <= err_next;
      if (start) begin
        wr_ptr <= BASE_C;
        count  <= '0;
        full   <= 1'b0;
      end else if (wr_en) begin
        mem_addr  <= wr_ptr;
        mem_wdata <= wr_data;
        wr_ptr    <= wr_ptr + 1'b1;
        count     <= count + 1'b1;
        full      <= (count + 1'b1 == DEPTH_C);
      end
      if (accept && in_li) lli_word <= {OP_LLI, in_rd, in_imm[7:0]};
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed steps followed by random bundles, checked
// against a word-level reference model of the encoder and loader.
module tb_prog_loader;
  import isa_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic              in_li = 1'b0;
  logic [3:0]        in_rd = '0;
  logic [3:0]        in_rs1 = '0;
  logic [3:0]        in_rs2 = '0;
  logic [15:0]       in_imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              err;
  load_state_t       state;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_li     (in_li),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .full      (full),
    .count     (count),
    .err       (err),
    .state     (state)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] data;
    bit          is_lli;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   fails = 0;
  int   ncyc = 0;
  int   err_due = -1;
  int   m_count = 0;
  int   exp_count = 0;
  bit   mon_on = 1'b0;
  bit   rewind_next = 1'b0;
  int   imm_tab [14] = '{-129, -128, -9, -8, -1, 0, 7, 8, 127, 128, 255, 256, -32768, 32767};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: one comparison set per cycle, sampled at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit   we_exp;
    bit   lli_next;
    if (mon_on) begin
      ncyc++;
      if (rewind_next) begin
        exp_count = 0;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= ncyc) void'(exp_q.pop_back());
        rewind_next = 1'b0;
      end
      we_exp = (exp_q.size() > 0) && (exp_q[0].due <= ncyc);
      chk("mem_we", {31'b0, mem_we}, {31'b0, we_exp});
      if (we_exp) begin
        e = exp_q.pop_front();
        chk("mem_addr", 32'(mem_addr), e.addr);
        chk("mem_wdata", 32'(mem_wdata), e.data);
        exp_count++;
      end
      chk("err", {31'b0, err}, {31'b0, ncyc == err_due});
      chk("count", 32'(count), exp_count);
      chk("full", {31'b0, full}, {31'b0, exp_count == DEPTH});
      lli_next = (exp_q.size() > 0) && (exp_q[0].due == ncyc + 1) && exp_q[0].is_lli;
      chk("in_ready", {31'b0, in_ready}, {31'b0, !start && !lli_next && (exp_count < DEPTH)});
      if (start) rewind_next = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input bit with_valid);
    start = 1'b1;
    if (with_valid) begin
      in_op = OP_ADD; in_li = 1'b0; in_rd = 4'd7; in_rs1 = 4'd7; in_rs2 = 4'd7; in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    in_valid = 1'b0;
    m_count = 0;
  endtask

  // Drives one bundle; on acceptance, predicts err or the written words.
  task automatic send(input logic [3:0] op, input bit li, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2, input int imm);
    int s;
    int u;
    int low;
    int wait_n;
    bit ok;
    in_op = op; in_li = li; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm[15:0];
    in_valid = 1'b1;
    s = int'($signed(in_imm));
    u = int'(in_imm);
    if (m_count >= DEPTH) begin
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    wait_n = 0;
    @(negedge clk);
    while (!in_ready && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    low = 0;
    if (li) begin
      ok = (m_count != DEPTH - 1);
    end else if (op inside {4'd0, 4'd1, 4'd2, 4'd3}) begin
      ok = 1'b1;
      low = int'(rs1) * 16 + int'(rs2);
    end else if (op inside {4'd4, 4'd8, 4'd9, 4'd10}) begin
      ok = (s >= -8) && (s <= 7);
      low = int'(rs1) * 16 + (s & 15);
    end else if (op inside {4'd5, 4'd15}) begin
      ok = (s >= 0) && (s <= 255);
      low = s & 255;
    end else begin
      ok = (s >= -128) && (s <= 127);
      low = s & 255;
    end
    if (!ok) begin
      err_due = ncyc + 1;
    end else if (li) begin
      exp_q.push_back('{due: ncyc + 1, addr: 32'(BASE_ADDR + m_count),
                        data: 32'(5 * 4096 + int'(rd) * 256 + u / 256), is_lli: 1'b0});
      exp_q.push_back('{due: ncyc + 2, addr: 32'(BASE_ADDR + m_count + 1),
                        data: 32'(15 * 4096 + int'(rd) * 256 + u % 256), is_lli: 1'b1});
      m_count += 2;
    end else begin
      exp_q.push_back('{due: ncyc + 1, addr: 32'(BASE_ADDR + m_count),
                        data: 32'(int'(op) * 4096 + int'(rd) * 256 + low), is_lli: 1'b0});
      m_count++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int imm;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_addr", 32'(mem_addr), 32'(BASE_ADDR));
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_state", {31'b0, state == ST_IDLE}, 32'd1);
    @(posedge clk);
    #1;

    // add 1,2,3 -> 0x0123 at address 0
    send(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd3, 0);
    idle(2);
    // back-to-back addi / lw
    start_pulse(1'b0);
    send(OP_ADDI, 1'b0, 4'd4, 4'd5, 4'd0, -1);
    send(OP_LW, 1'b0, 4'd1, 4'd2, 4'd0, 3);
    idle(2);
    // li rd=2, 0xBEEF
    start_pulse(1'b0);
    send(4'd0, 1'b1, 4'd2, 4'd0, 4'd0, 32'hBEEF);
    idle(3);
    // out-of-range addi, then a word at the same address
    start_pulse(1'b0);
    send(OP_ADDI, 1'b0, 4'd3, 4'd3, 4'd0, 8);
    send(OP_SUB, 1'b0, 4'd6, 4'd7, 4'd8, 0);
    idle(2);
    // fill: three words, li with one slot left, last word, then ignored bundle
    start_pulse(1'b0);
    send(OP_ADD, 1'b0, 4'd1, 4'd1, 4'd1, 0);
    send(OP_JAL, 1'b0, 4'd2, 4'd0, 4'd0, -128);
    send(OP_LUI, 1'b0, 4'd3, 4'd0, 4'd0, 255);
    send(4'd0, 1'b1, 4'd4, 4'd0, 4'd0, 16'h1234);
    send(OP_ADD, 1'b0, 4'd5, 4'd6, 4'd7, 0);
    send(OP_ADD, 1'b0, 4'd8, 4'd9, 4'd10, 0);
    idle(2);
    // start right after an accepted li aborts the lli word
    start_pulse(1'b0);
    send(4'd0, 1'b1, 4'd9, 4'd0, 4'd0, 16'hA55A);
    start_pulse(1'b0);
    send(OP_GRT, 1'b0, 4'd1, 4'd2, 4'd3, 0);
    idle(2);
    // start together with in_valid
    start_pulse(1'b1);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (m_count >= DEPTH || r == 0) begin
        start_pulse(1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        idle($urandom_range(1, 3));
      end else begin
        if ($urandom_range(0, 3) == 0) imm = $urandom_range(0, 65535);
        else imm = imm_tab[$urandom_range(0, 13)];
        send(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), imm);
      end
    end

    idle(4);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
